fm_voice_seq: RTL and testbench
===============================

# fm_voice_seq

Per-sample voice scheduler for the FM synthesis datapath. On every one-cycle sample-rate pulse from the clock generator, it walks the shared voice engine through voices 0..NVOICE-1 using a start/done handshake. It signals frame completion to the I2S serializer side and aborts any frame that exceeds its cycle budget. Overruns are flagged with a sticky status bit.

## Interface
Parameters:
- NVOICE, 8, voices per sample frame (1..2^VW)
- VW, 3, width of voice index
- BUDGET, 1024, max clk cycles per frame, counted from frame start (48 MHz / 46.875 kHz)
- BW, 10, width of budget counter (2^BW >= BUDGET)

Ports:
- clk  in  1  system clock (48 MHz)
- reset  in  1  synchronous, active-low reset
- rate  in  1  one-cycle sample-rate pulse
- ena  in  1  scheduler enable; when low, new rate pulses are ignored
- v_start  out  1  one-cycle start pulse to voice engine
- v_idx  out  VW  voice being computed; stable from v_start until the matching v_done
- v_done  in  1  one-cycle completion pulse from voice engine
- frame_done  out  1  one-cycle pulse: all voices finished normally
- busy  out  1  frame in progress
- overrun  out  1  sticky error flag
- clr_ovr  in  1  clears overrun

## Operation
- States: IDLE, START, WAIT, FIN.
- IDLE:
  - rate & ena -> START, v_idx <= 0, budget counter <= 0.
  - rate & !ena -> stay in IDLE, no flag.
- START: v_start = 1 for exactly one cycle -> WAIT.
- WAIT:
  - v_done with v_idx < NVOICE-1 -> START, v_idx <= v_idx+1.
  - v_done with v_idx == NVOICE-1 -> FIN.
- FIN: frame_done = 1 for one cycle -> IDLE. v_idx holds its last value.
- busy = 1 in START, WAIT and FIN.
- v_done outside WAIT is ignored. This includes v_done coincident with v_start.
- Budget counter:
  - Increments every cycle while busy; held at 0 in IDLE.
  - Count == BUDGET-1 while in START or WAIT -> abort: go to IDLE next cycle, no frame_done, overrun <= 1.
  - Abort takes priority over a coincident v_done.
  - A frame reaching FIN on or before count BUDGET-1 is not aborted.
- rate while busy (any state other than IDLE): overrun <= 1. The pulse is otherwise ignored; no restart, no queueing.
- overrun:
  - Cleared by clr_ovr.
  - Set has priority over a coincident clr_ovr.
- ena falling mid-frame has no effect on the current frame.

## Timing
- Reset (reset == 0 at clk edge): state IDLE, v_start 0, v_idx 0, frame_done 0, busy 0, overrun 0, budget counter 0. Reset overrides every event in the same cycle, including mid-frame; no frame_done is emitted.
- rate high at edge N (IDLE, ena=1): busy = 1 and v_start = 1 with v_idx = 0 during cycle N+1.
- v_done high at edge M in WAIT: v_start for the next voice in cycle M+1, with v_idx already incremented.
- Minimum cost per voice is 2 cycles (start pulse, then a done one cycle later). The minimum frame is 2*NVOICE+1 cycles from rate to frame_done.
- Last v_done at edge M: frame_done = 1 in cycle M+1; busy falls at M+2.
- A rate pulse arriving on the same edge that FIN returns to IDLE counts as "while busy": overrun is set and no frame starts.
- Abort: busy falls on the cycle after count BUDGET-1 is observed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Normal frame, NVOICE=8:
  - Stimulus: rate at cycle 10; engine answers v_done 3 cycles after each v_start.
  - Expected: v_idx steps 0..7; eight v_start pulses, 4 cycles apart; frame_done once; overrun 0.
- Minimum latency:
  - Stimulus: v_done on the cycle right after each v_start.
  - Expected: frame_done exactly 17 cycles after rate; busy low on the following cycle.
- Budget abort, BUDGET=1024:
  - Stimulus: engine never answers voice 5.
  - Expected: busy drops the cycle after count 1023; no frame_done; overrun=1. A subsequent rate starts a clean frame at v_idx=0.
- Rate while busy:
  - Stimulus: second rate pulse during WAIT of voice 2.
  - Expected: frame continues unchanged to frame_done; overrun=1.
  - Stimulus: clr_ovr on the same cycle as another set event.
  - Expected: overrun stays 1.
- ena and stray done:
  - Stimulus: rate with ena=0.
  - Expected: no v_start.
  - Stimulus: v_done pulses in IDLE and coincident with v_start.
  - Expected: ignored; v_idx unchanged.
- Reset mid-frame:
  - Stimulus: reset=0 for 1 cycle during WAIT of voice 4.
  - Expected: all outputs at reset values on the next cycle; no frame_done; the next rate starts at voice 0.

Source files
------------

// File: rtl/fm_voice_seq.sv
// Per-sample voice scheduler: walks the shared FM voice engine through every
// voice once per sample frame, with a per-frame cycle budget and sticky overrun.
module fm_voice_seq #(
  parameter int NVOICE = 8,
  parameter int VW     = 3,
  parameter int BUDGET = 1024,
  parameter int BW     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rate,
  input  logic          ena,
  output logic          v_start,
  output logic [VW-1:0] v_idx,
  input  logic          v_done,
  output logic          frame_done,
  output logic          busy,
  output logic          overrun,
  input  logic          clr_ovr
);

  typedef enum logic [1:0] {IDLE, START, WAIT, FIN} state_t;

  localparam logic [VW-1:0] LAST_IDX = VW'(NVOICE - 1);
  localparam logic [BW-1:0] LAST_CNT = BW'(BUDGET - 1);

  state_t        state_q, state_d;
  logic [VW-1:0] idx_q, idx_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic          expired;
  logic          ovr_set;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    ovr_d   = ovr_q;
    ovr_set = 1'b0;
    // The budget only guards voice work; a frame already in FIN always completes.
    expired = ((state_q == START) || (state_q == WAIT)) && (cnt_q == LAST_CNT);

    unique case (state_q)
      IDLE: begin
        if (rate && ena) begin
          state_d = START;
          idx_d   = '0;
        end
      end
      START: begin
        state_d = expired ? IDLE : WAIT;
      end
      WAIT: begin
        if (expired) begin
          state_d = IDLE;
        end else if (v_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            state_d = START;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (expired || (rate && (state_q != IDLE))) begin
      ovr_set = 1'b1;
    end
    if (state_d == IDLE) begin
      cnt_d = '0;
    end

    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  assign v_start    = (state_q == START);
  assign frame_done = (state_q == FIN);
  assign busy       = (state_q != IDLE);
  assign v_idx      = idx_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_fm_voice_seq.sv
// Self-checking bench for fm_voice_seq: directed scenarios followed by a random
// phase, every cycle compared against a frame-age based reference model.
module tb_fm_voice_seq;

  localparam int NVOICE = 8;
  localparam int VW     = 3;
  localparam int BUDGET = 1024;
  localparam int BW     = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rate = 1'b0;
  logic          ena = 1'b0;
  logic          v_done = 1'b0;
  logic          clr_ovr = 1'b0;
  logic          v_start;
  logic [VW-1:0] v_idx;
  logic          frame_done;
  logic          busy;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  // Reference model: a frame is described by its age in cycles since start,
  // the current voice, the age at which that voice was started, and the age
  // at which frame completion is reported (-1 while voices are still running).
  int age     = -1;
  int voice   = 0;
  int startAt = 0;
  int finAt   = -1;
  bit mOvr    = 1'b0;

  // Voice engine emulation and observation bookkeeping.
  int cyc       = 0;
  int doneAt    = -1;
  int strayAt   = -1;
  int dly       = 3;
  int skipVoice = -1;
  bit coinc     = 1'b0;
  bit noise     = 1'b0;
  bit randDly   = 1'b0;
  bit forceDone = 1'b0;
  int dutStarts = 0;
  int dutFd     = 0;
  int dutFdCyc  = -1;

  always #5 clk = ~clk;

  fm_voice_seq #(
    .NVOICE(NVOICE),
    .VW    (VW),
    .BUDGET(BUDGET),
    .BW    (BW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rate      (rate),
    .ena       (ena),
    .v_start   (v_start),
    .v_idx     (v_idx),
    .v_done    (v_done),
    .frame_done(frame_done),
    .busy      (busy),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  function automatic bit expBusy();
    return age >= 0;
  endfunction

  function automatic bit expStart();
    return (age >= 0) && (finAt < 0) && (age == startAt);
  endfunction

  function automatic bit expFd();
    return (age >= 0) && (finAt >= 0) && (age == finAt);
  endfunction

  function automatic bit inWait(int v);
    return (age >= 0) && (finAt < 0) && (voice == v) && (age > startAt);
  endfunction

  function automatic void modelStep();
    bit setO;
    setO = 1'b0;
    if (!reset) begin
      age = -1; voice = 0; startAt = 0; finAt = -1; mOvr = 1'b0;
      return;
    end
    if (age < 0) begin
      if (rate && ena) begin
        age = 0; voice = 0; startAt = 0; finAt = -1;
      end
    end else begin
      if (rate) setO = 1'b1;
      if (finAt >= 0) begin
        age = -1;
      end else if (age == BUDGET - 1) begin
        setO = 1'b1;
        age  = -1;
      end else begin
        if (v_done && (age > startAt)) begin
          if (voice == NVOICE - 1) begin
            finAt = age + 1;
          end else begin
            voice   = voice + 1;
            startAt = age + 1;
          end
        end
        age = age + 1;
      end
    end
    if (setO) mOvr = 1'b1;
    else if (clr_ovr) mOvr = 1'b0;
  endfunction

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic boundCheck(input string name, input bit ok);
    total++;
    assert (ok)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=timeout expected=event", name);
    end
  endtask

  task automatic checkOutput();
    cmp($sformatf("c%0d busy", cyc), 32'(busy), 32'(expBusy()));
    cmp($sformatf("c%0d v_start", cyc), 32'(v_start), 32'(expStart()));
    cmp($sformatf("c%0d frame_done", cyc), 32'(frame_done), 32'(expFd()));
    cmp($sformatf("c%0d v_idx", cyc), 32'(v_idx), 32'(voice));
    cmp($sformatf("c%0d overrun", cyc), 32'(overrun), 32'(mOvr));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    cyc++;
    checkOutput();
    if (v_start === 1'b1) dutStarts++;
    if (frame_done === 1'b1) begin
      dutFd++;
      dutFdCyc = cyc;
    end
    if (expStart()) begin
      if (randDly) dly = $urandom_range(1, 5);
      if (voice != skipVoice) doneAt = cyc + dly;
      if (coinc) strayAt = cyc;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit c, input bit rstN);
    rate      = r;
    ena       = e;
    clr_ovr   = c;
    reset     = rstN;
    v_done    = (cyc == doneAt) || (cyc == strayAt) || forceDone ||
                (noise && ($urandom_range(0, 15) == 0));
    forceDone = 1'b0;
  endtask

  task automatic step(input bit r, input bit e, input bit c, input bit rstN);
    applyStimulus(r, e, c, rstN);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic waitVoice(input string name, input int v);
    int n;
    n = 0;
    while (!inWait(v) && n < 300) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n++;
    end
    boundCheck(name, inWait(v));
  endtask

  initial begin
    int rateCyc;

    // Reset
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    $display("[TB] reset applied");

    // Normal frame, rate at cycle 10, done 3 cycles after each start
    dly = 3;
    while (cyc < 9) step(1'b0, 1'b1, 1'b0, 1'b1);
    dutStarts = 0; dutFd = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(40);
    cmp("normal starts", 32'(dutStarts), 32'(NVOICE));
    cmp("normal frame_done count", 32'(dutFd), 32'd1);

    // Minimum latency
    dly = 1; dutFdCyc = -1;
    rateCyc = cyc;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(25);
    cmp("min latency", 32'(dutFdCyc - rateCyc), 32'(2 * NVOICE + 1));

    // Budget abort, engine never answers voice 5
    dly = 2; skipVoice = 5; dutFd = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(BUDGET + 20);
    cmp("abort frame_done count", 32'(dutFd), 32'd0);
    cmp("abort overrun", 32'(overrun), 32'd1);
    skipVoice = -1;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    cmp("restart v_idx", 32'(v_idx), 32'd0);
    idle(30);

    // Rate while busy during WAIT of voice 2
    dly = 3; dutFd = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    waitVoice("wait voice2", 2);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(40);
    cmp("busy-rate frame_done", 32'(dutFd), 32'd1);
    cmp("busy-rate overrun", 32'(overrun), 32'd1);

    // clr_ovr coincident with a set event
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    cmp("clr vs set overrun", 32'(overrun), 32'd1);
    idle(40);

    // ena low, stray done in IDLE and coincident with v_start
    dutStarts = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    forceDone = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    cmp("ena low starts", 32'(dutStarts), 32'd0);
    coinc = 1'b1; dly = 2; dutFd = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(40);
    coinc = 1'b0; strayAt = -1;
    cmp("coincident done frame_done", 32'(dutFd), 32'd1);

    // Reset mid-frame during WAIT of voice 4
    dly = 3; dutFd = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    waitVoice("wait voice4", 4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    cmp("midreset busy", 32'(busy), 32'd0);
    doneAt = -1;
    idle(10);
    cmp("midreset frame_done", 32'(dutFd), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    cmp("post-reset v_idx", 32'(v_idx), 32'd0);
    idle(40);

    // Random phase
    noise = 1'b1; randDly = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 399) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
